event_unit_sleep_ctrl: RTL and testbench



---
 rtl/event_unit_sleep_ctrl_pkg.sv | 20 ++
 rtl/event_unit_sleep_ctrl_if.sv | 43 ++++
 rtl/event_unit_delay_cnt.sv | 38 +++
 rtl/event_unit_sleep_ctrl.sv | 136 +++++++++++++
 tb/tb_event_unit_sleep_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/event_unit_sleep_ctrl_pkg.sv
// Shared types and constants for the per-core wait-for-event sleep controller.
package event_unit_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DRAIN = 3'd1,
      SLEEP = 3'd2,
      WAKE  = 3'd3,
      RESP  = 3'd4
   } sleep_state_e;

   localparam int EVNT_STATUS_W   = 32;
   localparam int DEF_SLEEP_DELAY = 2;
   localparam int DEF_WAKE_DELAY  = 2;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/event_unit_sleep_ctrl_if.sv
// Core-side wait handshake plus event buffer/mask side signals of one sleep controller.
// slave: the controller; master: the core / event unit environment.
interface event_unit_sleep_ctrl_if;
   import event_unit_ctrl_pkg::*;

   logic                     sleep_req_i;
   logic                     clear_on_wake_i;
   logic                     req_ready_o;
   logic                     core_busy_i;
   logic                     event_detect_i;
   logic [EVNT_STATUS_W-1:0] event_status_i;
   logic                     rd_valid_o;
   logic [EVNT_STATUS_W-1:0] rd_data_o;
   logic [EVNT_STATUS_W-1:0] evnt_buffer_clear_o;
   logic                     core_clock_en_o;

   modport slave (
      input  sleep_req_i,
      input  clear_on_wake_i,
      input  core_busy_i,
      input  event_detect_i,
      input  event_status_i,
      output req_ready_o,
      output rd_valid_o,
      output rd_data_o,
      output evnt_buffer_clear_o,
      output core_clock_en_o
   );

   modport master (
      output sleep_req_i,
      output clear_on_wake_i,
      output core_busy_i,
      output event_detect_i,
      output event_status_i,
      input  req_ready_o,
      input  rd_valid_o,
      input  rd_data_o,
      input  evnt_buffer_clear_o,
      input  core_clock_en_o
   );

endinterface

// File: rtl/event_unit_delay_cnt.sv
// Clearable saturating delay counter with terminal-count compare.
// Shared by the drain (idle-cycle) and wake (clock-run) phases of the sleep FSM.
module event_unit_delay_cnt #(
   parameter int CNT_W = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             inc_i,
   input  logic [CNT_W-1:0] term_i,
   output logic             tc_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Clear wins over increment; increment stops at all-ones so the count never wraps.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/event_unit_sleep_ctrl.sv
// Per-core wait-for-event controller: holds a wait read until an event is pending,
// gates the core clock while waiting, and returns the masked event status on wake.
module event_unit_sleep_ctrl
   import event_unit_ctrl_pkg::*;
#(
   parameter int SLEEP_DELAY = DEF_SLEEP_DELAY,
   parameter int WAKE_DELAY  = DEF_WAKE_DELAY
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   event_unit_sleep_ctrl_if.slave bus
);

   localparam int CNT_W = $clog2(max_int(SLEEP_DELAY, WAKE_DELAY) + 1);
   localparam logic [CNT_W-1:0] SLEEP_TERM = CNT_W'(SLEEP_DELAY - 1);
   localparam logic [CNT_W-1:0] WAKE_TERM  = CNT_W'(WAKE_DELAY - 1);

   sleep_state_e             state_q, state_d;
   logic                     clr_flag_q, clr_flag_d;
   logic                     rd_valid_q, rd_valid_d;
   logic [EVNT_STATUS_W-1:0] rd_data_q, rd_data_d;
   logic [EVNT_STATUS_W-1:0] clear_q, clear_d;
   logic                     clk_en_q, clk_en_d;

   logic             cnt_clr;
   logic             cnt_inc;
   logic [CNT_W-1:0] cnt_term;
   logic             cnt_tc;

   event_unit_delay_cnt #(
      .CNT_W (CNT_W)
   ) u_delay_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (cnt_clr),
      .inc_i  (cnt_inc),
      .term_i (cnt_term),
      .tc_o   (cnt_tc)
   );

   // Next-state logic and counter control; any state change restarts the counter.
   always_comb begin
      state_d    = state_q;
      clr_flag_d = clr_flag_q;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      cnt_term   = '0;

      case (state_q)
         IDLE: begin
            if (bus.sleep_req_i) begin
               clr_flag_d = bus.clear_on_wake_i;
               state_d    = bus.event_detect_i ? RESP : DRAIN;
            end
         end
         DRAIN: begin
            cnt_term = SLEEP_TERM;
            // A pending event aborts the drain before any gating decision.
            if (bus.event_detect_i) begin
               state_d = RESP;
            end else if (bus.core_busy_i) begin
               cnt_clr = 1'b1;
            end else if (cnt_tc) begin
               state_d = SLEEP;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         SLEEP: begin
            if (bus.event_detect_i) begin
               state_d = WAKE;
            end
         end
         WAKE: begin
            // Event dropping here does not abort; the wake always completes.
            cnt_term = WAKE_TERM;
            if (cnt_tc) begin
               state_d = RESP;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (state_d != state_q) begin
         cnt_clr = 1'b1;
      end
   end

   // Registered outputs: status is captured on RESP entry; the clock gate closes
   // one cycle after SLEEP entry and reopens on the wake transition.
   always_comb begin
      rd_valid_d = (state_d == RESP);
      rd_data_d  = rd_data_q;
      clear_d    = '0;
      clk_en_d   = !((state_q == SLEEP) && (state_d == SLEEP));
      if (state_d == RESP) begin
         rd_data_d = bus.event_status_i;
         if (clr_flag_d) begin
            clear_d = bus.event_status_i;
         end
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         clr_flag_q <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         clear_q    <= '0;
         clk_en_q   <= 1'b1;
      end else begin
         state_q    <= state_d;
         clr_flag_q <= clr_flag_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         clear_q    <= clear_d;
         clk_en_q   <= clk_en_d;
      end
   end

   assign bus.req_ready_o         = (state_q == IDLE);
   assign bus.rd_valid_o          = rd_valid_q;
   assign bus.rd_data_o           = rd_data_q;
   assign bus.evnt_buffer_clear_o = clear_q;
   assign bus.core_clock_en_o     = clk_en_q;

endmodule

// File: tb/tb_event_unit_sleep_ctrl.sv
// Directed table-driven bench for event_unit_sleep_ctrl (SLEEP_DELAY=2, WAKE_DELAY=2).
// Each row's inputs are driven at a falling edge; its expected outputs are those
// visible after the following rising edge has consumed them.
module tb_event_unit_sleep_ctrl;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   valid_pulses;
   int   accepted;

   event_unit_sleep_ctrl_if bus();

   event_unit_sleep_ctrl #(
      .SLEEP_DELAY (2),
      .WAKE_DELAY  (2)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   typedef struct {
      logic        req;
      logic        cow;
      logic        busy;
      logic        ev;
      logic [31:0] st;
      logic        rdy;
      logic        vld;
      logic [31:0] data;
      logic [31:0] clr;
      logic        cen;
   } vec_t;

   localparam int NVEC = 26;
   vec_t vecs[NVEC];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count response pulses to confirm one response per accepted request.
   always @(negedge clk) begin
      if (rst_n && bus.rd_valid_o) valid_pulses++;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

   function automatic vec_t mk(input logic req, input logic cow, input logic busy,
                               input logic ev, input logic [31:0] st, input logic rdy,
                               input logic vld, input logic [31:0] data,
                               input logic [31:0] clr, input logic cen);
      vec_t v;
      v.req = req; v.cow = cow; v.busy = busy; v.ev = ev; v.st = st;
      v.rdy = rdy; v.vld = vld; v.data = data; v.clr = clr; v.cen = cen;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic req, input logic cow, input logic busy,
                        input logic ev, input logic [31:0] st);
      bus.sleep_req_i     = req;
      bus.clear_on_wake_i = cow;
      bus.core_busy_i     = busy;
      bus.event_detect_i  = ev;
      bus.event_status_i  = st;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int n;
      checks       = 0;
      errors       = 0;
      valid_pulses = 0;
      accepted     = 0;
      rst_n        = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

      //            req  cow  busy ev   status        rdy  vld  data          clear         cen
      // Pending event at request: immediate response with clear.
      vecs[0]  = mk(1'b1,1'b1,1'b0,1'b1,32'h0000_0021,1'b0,1'b1,32'h0000_0021,32'h0000_0021,1'b1);
      vecs[1]  = mk(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0000_0021,32'h0,        1'b1);
      // Normal sleep and wake, no clear; request during SLEEP ignored.
      vecs[2]  = mk(1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0000_0021,32'h0,        1'b1);
      vecs[3]  = mk(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0000_0021,32'h0,        1'b1);
      vecs[4]  = mk(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0000_0021,32'h0,        1'b1);
      vecs[5]  = mk(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0000_0021,32'h0,        1'b0);
      vecs[6]  = mk(1'b1,1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0000_0021,32'h0,        1'b0);
      vecs[7]  = mk(1'b0,1'b0,1'b0,1'b1,32'h0000_0400,1'b0,1'b0,32'h0000_0021,32'h0,        1'b1);
      vecs[8]  = mk(1'b0,1'b0,1'b0,1'b1,32'h0000_0400,1'b0,1'b0,32'h0000_0021,32'h0,        1'b1);
      vecs[9]  = mk(1'b0,1'b0,1'b0,1'b1,32'h0000_0400,1'b0,1'b1,32'h0000_0400,32'h0,        1'b1);
      vecs[10] = mk(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0000_0400,32'h0,        1'b1);
      // Busy drain 0,1,0,0; then event drops during WAKE so captured status is 0.
      vecs[11] = mk(1'b1,1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0000_0400,32'h0,        1'b1);
      vecs[12] = mk(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0000_0400,32'h0,        1'b1);
      vecs[13] = mk(1'b0,1'b0,1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0000_0400,32'h0,        1'b1);
      vecs[14] = mk(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0000_0400,32'h0,        1'b1);
      vecs[15] = mk(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0000_0400,32'h0,        1'b1);
      vecs[16] = mk(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0000_0400,32'h0,        1'b0);
      vecs[17] = mk(1'b0,1'b0,1'b0,1'b1,32'h0000_0005,1'b0,1'b0,32'h0000_0400,32'h0,        1'b1);
      vecs[18] = mk(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0000_0400,32'h0,        1'b1);
      vecs[19] = mk(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h0,        32'h0,        1'b1);
      vecs[20] = mk(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,        32'h0,        1'b1);
      // Abort in DRAIN on the cycle the gating condition holds.
      vecs[21] = mk(1'b1,1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        32'h0,        1'b1);
      vecs[22] = mk(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,        32'h0,        1'b1);
      vecs[23] = mk(1'b0,1'b0,1'b0,1'b1,32'h8000_0001,1'b0,1'b1,32'h8000_0001,32'h8000_0001,1'b1);
      vecs[24] = mk(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h8000_0001,32'h0,        1'b1);
      // Event pending without a request produces nothing.
      vecs[25] = mk(1'b0,1'b0,1'b0,1'b1,32'h0000_0077,1'b1,1'b0,32'h8000_0001,32'h0,        1'b1);

      // Reset values while reset is held.
      repeat (2) @(negedge clk);
      check("reset_ready", 32'(bus.req_ready_o), 32'd1);
      check("reset_valid", 32'(bus.rd_valid_o), 32'd0);
      check("reset_data", bus.rd_data_o, 32'h0);
      check("reset_clear", bus.evnt_buffer_clear_o, 32'h0);
      check("reset_clk_en", 32'(bus.core_clock_en_o), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven vectors.
      for (int i = 0; i < NVEC; i++) begin
         drive(vecs[i].req, vecs[i].cow, vecs[i].busy, vecs[i].ev, vecs[i].st);
         if (vecs[i].req && bus.req_ready_o) accepted++;
         step();
         $display("vec %0d: req=%b busy=%b ev=%b st=%08h -> rdy=%b vld=%b data=%08h clr=%08h cen=%b",
                  i, vecs[i].req, vecs[i].busy, vecs[i].ev, vecs[i].st, bus.req_ready_o,
                  bus.rd_valid_o, bus.rd_data_o, bus.evnt_buffer_clear_o, bus.core_clock_en_o);
         check($sformatf("vec%0d_ready", i), 32'(bus.req_ready_o), 32'(vecs[i].rdy));
         check($sformatf("vec%0d_valid", i), 32'(bus.rd_valid_o), 32'(vecs[i].vld));
         check($sformatf("vec%0d_data", i), bus.rd_data_o, vecs[i].data);
         check($sformatf("vec%0d_clear", i), bus.evnt_buffer_clear_o, vecs[i].clr);
         check($sformatf("vec%0d_clk_en", i), 32'(bus.core_clock_en_o), 32'(vecs[i].cen));
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

      // Latency sequence: gate 3 cycles after acceptance, response WAKE_DELAY+1 after event.
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      accepted++;
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      n = 0;
      while (n < 10) begin
         step();
         n++;
         if (!bus.core_clock_en_o) break;
      end
      check("gate_latency", 32'(n), 32'd3);
      $display("seq gate: clock gated after %0d cycles", n);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_abcd);
      n = 0;
      while (n < 10) begin
         step();
         n++;
         if (bus.rd_valid_o) break;
      end
      check("wake_latency", 32'(n), 32'd3);
      check("wake_data", bus.rd_data_o, 32'h0000_abcd);
      check("wake_clear", bus.evnt_buffer_clear_o, 32'h0000_abcd);
      $display("seq wake: response after %0d cycles data=%08h", n, bus.rd_data_o);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      step();

      // Reset mid-sleep: gate must reopen without waiting for a clock edge.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      accepted++;
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      n = 0;
      while (n < 10) begin
         step();
         n++;
         if (!bus.core_clock_en_o) break;
      end
      check("rst_seq_gated", 32'(bus.core_clock_en_o), 32'd0);
      rst_n = 1'b0;
      #1;
      check("rst_async_clk_en", 32'(bus.core_clock_en_o), 32'd1);
      check("rst_async_ready", 32'(bus.req_ready_o), 32'd1);
      check("rst_async_data", bus.rd_data_o, 32'h0);
      $display("seq reset: clk_en=%b ready=%b during reset", bus.core_clock_en_o, bus.req_ready_o);
      // This accepted request is lost to reset and never answered.
      accepted--;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("rst_rel_ready", 32'(bus.req_ready_o), 32'd1);
      check("rst_rel_valid", 32'(bus.rd_valid_o), 32'd0);
      check("rst_rel_clk_en", 32'(bus.core_clock_en_o), 32'd1);

      // Controller works again after reset.
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0003);
      accepted++;
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check("post_rst_valid", 32'(bus.rd_valid_o), 32'd1);
      check("post_rst_data", bus.rd_data_o, 32'h0000_0003);
      check("post_rst_clear", bus.evnt_buffer_clear_o, 32'h0);
      $display("seq post-reset: vld=%b data=%08h", bus.rd_valid_o, bus.rd_data_o);
      step();
      step();

      check("response_count", 32'(valid_pulses), 32'(accepted));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
